// File: rtl/vga_image_scaler.sv
// vga_image_scaler: VGA raster engine that scans a configurable timing grid,
// fetches pixels from NUM_IMG external image ROMs through a shared address,
// and places the selected (optionally power-of-two upscaled) image at a fixed
// offset inside the active area. RGB and syncs leave through the same
// two-stage pipeline, so they stay mutually aligned.
module vga_image_scaler #(
  parameter int          CLK_DIV    = 4,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          H_ACT      = 640,
  parameter int          H_FP       = 16,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          V_ACT      = 480,
  parameter int          V_FP       = 10,
  parameter int          IMG_W      = 320,
  parameter int          IMG_H      = 240,
  parameter int          SCALE_LOG2 = 0,
  parameter int          X_OFF      = 160,
  parameter int          Y_OFF      = 120,
  parameter int          NUM_IMG    = 3,
  parameter logic [11:0] BORDER_RGB = 12'hF00,
  parameter int          AW         = 17
) (
  input  logic                   CLK,
  input  logic                   init,
  input  logic [2:0]             num,
  output logic [AW-1:0]          addr,
  input  logic [12*NUM_IMG-1:0]  img_data,
  output logic [3:0]             red,
  output logic [3:0]             green,
  output logic [3:0]             blue,
  output logic                   H_sync,
  output logic                   V_sync,
  output logic                   de,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV);

  // Boundaries widened to 32 bits so all compares share one width.
  localparam logic [31:0] H_SY  = 32'(H_SYNC);
  localparam logic [31:0] H_ST  = 32'(H_SYNC + H_BP);
  localparam logic [31:0] H_EN  = 32'(H_SYNC + H_BP + H_ACT);
  localparam logic [31:0] V_SY  = 32'(V_SYNC);
  localparam logic [31:0] V_ST  = 32'(V_SYNC + V_BP);
  localparam logic [31:0] V_EN  = 32'(V_SYNC + V_BP + V_ACT);
  localparam logic [31:0] X_LO  = 32'(X_OFF);
  localparam logic [31:0] X_HI  = 32'(X_OFF + (IMG_W << SCALE_LOG2));
  localparam logic [31:0] Y_LO  = 32'(Y_OFF);
  localparam logic [31:0] Y_HI  = 32'(Y_OFF + (IMG_H << SCALE_LOG2));
  localparam logic [31:0] IMG_W32 = 32'(IMG_W);

  logic [DW-1:0] div_q;
  logic          pix_ce;
  logic [HW-1:0] h_cnt_q;
  logic [VW-1:0] v_cnt_q;
  logic [2:0]    sel_q;
  logic [2:0]    sel_d;

  logic [31:0]   hx, vy, xp, yp, col, row;
  logic          act_h, act_v, act_d, win_d, first_d;
  logic [AW-1:0] addr_d;
  logic [11:0]   bank_pix;

  logic [AW-1:0] addr_q;
  logic          act_p1_q, win_p1_q, hs_p1_q, vs_p1_q, first_p1_q;
  logic [11:0]   rgb_p2_q;
  logic          de_p2_q, hs_p2_q, vs_p2_q, fs_q;

  assign pix_ce = (div_q == '0);

  // Pixel-clock divider; zero after reset so the first released cycle ticks.
  always_ff @(posedge CLK) begin
    if (init) begin
      div_q <= '0;
    end else if (div_q == DW'(CLK_DIV - 1)) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Raster counters: h wraps every line, v advances on each h wrap.
  always_ff @(posedge CLK) begin
    if (init) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (pix_ce) begin
      if (h_cnt_q == HW'(H_TOTAL - 1)) begin
        h_cnt_q <= '0;
        if (v_cnt_q == VW'(V_TOTAL - 1)) begin
          v_cnt_q <= '0;
        end else begin
          v_cnt_q <= v_cnt_q + VW'(1);
        end
      end else begin
        h_cnt_q <= h_cnt_q + HW'(1);
      end
    end
  end

  // Out-of-range selections fall back to bank 0.
  assign sel_d = (32'(num) < 32'(NUM_IMG)) ? num : 3'd0;

  // Bank select only changes at the top of a frame so an image never tears.
  always_ff @(posedge CLK) begin
    if (init) begin
      sel_q <= 3'd0;
    end else if (pix_ce && (h_cnt_q == '0) && (v_cnt_q == '0)) begin
      sel_q <= sel_d;
    end
  end

  // Decode counter position into active/window flags and the ROM address.
  always_comb begin
    hx      = 32'(h_cnt_q);
    vy      = 32'(v_cnt_q);
    xp      = hx - H_ST;
    yp      = vy - V_ST;
    act_h   = (hx >= H_ST) && (hx < H_EN);
    act_v   = (vy >= V_ST) && (vy < V_EN);
    act_d   = act_h && act_v;
    // Requiring act_d clips the window to the active area.
    win_d   = act_d && (xp >= X_LO) && (xp < X_HI) && (yp >= Y_LO) && (yp < Y_HI);
    col     = (xp - X_LO) >> SCALE_LOG2;
    row     = (yp - Y_LO) >> SCALE_LOG2;
    addr_d  = AW'((row * IMG_W32) + col);
    first_d = act_d && (xp == 32'd0) && (yp == 32'd0);
  end

  // ---- stage 1: address and flags registered from the counters ----
  always_ff @(posedge CLK) begin
    if (init) begin
      addr_q     <= '0;
      act_p1_q   <= 1'b0;
      win_p1_q   <= 1'b0;
      hs_p1_q    <= 1'b1;
      vs_p1_q    <= 1'b1;
      first_p1_q <= 1'b0;
    end else if (pix_ce) begin
      act_p1_q   <= act_d;
      win_p1_q   <= win_d;
      hs_p1_q    <= (hx >= H_SY);
      vs_p1_q    <= (vy >= V_SY);
      first_p1_q <= first_d;
      // Outside the window the address holds, so clipped pixels are never fetched.
      if (win_d) begin
        addr_q <= addr_d;
      end
    end
  end

  // Pick the selected bank's word out of the concatenated ROM outputs.
  always_comb begin
    bank_pix = img_data[11:0];
    for (int k = 1; k < NUM_IMG; k++) begin
      if (sel_q == 3'(k)) begin
        bank_pix = img_data[12*k +: 12];
      end
    end
  end

  // ---- stage 2: colour from ROM data, flags forwarded ----
  always_ff @(posedge CLK) begin
    if (init) begin
      rgb_p2_q <= 12'h000;
      de_p2_q  <= 1'b0;
      hs_p2_q  <= 1'b1;
      vs_p2_q  <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      // frame_start lasts a single CLK, not a whole pixel.
      fs_q <= 1'b0;
      if (pix_ce) begin
        de_p2_q <= act_p1_q;
        hs_p2_q <= hs_p1_q;
        vs_p2_q <= vs_p1_q;
        fs_q    <= first_p1_q;
        if (win_p1_q) begin
          rgb_p2_q <= bank_pix;
        end else if (act_p1_q) begin
          rgb_p2_q <= BORDER_RGB;
        end else begin
          rgb_p2_q <= 12'h000;
        end
      end
    end
  end

  assign addr        = addr_q;
  assign red         = rgb_p2_q[11:8];
  assign green       = rgb_p2_q[7:4];
  assign blue        = rgb_p2_q[3:0];
  assign H_sync      = hs_p2_q;
  assign V_sync      = vs_p2_q;
  assign de          = de_p2_q;
  assign frame_start = fs_q;

endmodule

// File: doc/vga_image_scaler.md
# vga_image_scaler

Parametrised VGA raster engine that scans a configurable timing grid, fetches pixels from up to NUM_IMG external single-port image ROMs, and places a selectable image, optionally integer-upscaled, at a fixed offset inside the active area. It sits between the image block memories and the board VGA connector and supersedes the fixed 640x480, 3-image display block. Added behaviour: selectable pixel-clock divide, power-of-two upscaling, frame-synchronous image switching, true black blanking, and sync outputs pipeline-aligned with RGB.

## Interface
- CLK_DIV, 4: CLK cycles per pixel; must be >= 2
- H_SYNC / H_BP / H_ACT / H_FP, 96 / 48 / 640 / 16: horizontal timing in pixels
- V_SYNC / V_BP / V_ACT / V_FP, 2 / 33 / 480 / 10: vertical timing in lines
- IMG_W / IMG_H, 320 / 240: stored image size in pixels
- SCALE_LOG2, 0: display upscale factor = 2^SCALE_LOG2 in both axes
- X_OFF / Y_OFF, 160 / 120: image top-left within the active area
- NUM_IMG, 3: number of image banks, 1..8
- BORDER_RGB, 12'hF00: colour of the active area outside the image
- AW, 17: address width; 2^AW >= IMG_W*IMG_H
- Ports:
- CLK  in  1  system clock; the only clock
- init  in  1  synchronous, active-high reset
- num  in  3  image select; values >= NUM_IMG select bank 0
- addr  out  AW  shared read address to all image ROMs
- img_data  in  12*NUM_IMG  bank k on bits [12k+11:12k], {R,G,B} 4 bits each, valid 1 CLK after addr
- red / green / blue  out  4 each  pixel colour
- H_sync / V_sync  out  1  active-low syncs
- de  out  1  high during active-area pixels
- frame_start  out  1  one-CLK pulse when output pixel (0,0) of the active area is presented

## Operation
- Pixel enable pix_ce: div counter 0..CLK_DIV-1, pix_ce = (div == 0); counter is 0 at reset, so the first cycle after reset is a tick.
- h_cnt 0..H_TOTAL-1 advances on pix_ce and wraps; v_cnt advances when h_cnt wraps and itself wraps at V_TOTAL-1. H_TOTAL = sum of the H parameters; V_TOTAL likewise.
- Active: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT), v_cnt similarly. x, y = position within active area.
- Image window: x in [X_OFF, X_OFF + IMG_W<<SCALE_LOG2), y similarly; col = (x-X_OFF)>>SCALE_LOG2, row = (y-Y_OFF)>>SCALE_LOG2; addr = row*IMG_W + col (AW bits, no wrap possible by construction).
- Outside the window, addr holds its last value.
- Colour: in window, the selected bank's img_data; active outside window, BORDER_RGB; blanking, 0.
- Bank select: num is sampled into sel_q only on the pix_ce with h_cnt==0 and v_cnt==0; mid-frame changes never tear the image.
- Window clipped by the active area when X_OFF/Y_OFF plus the scaled size exceeds it; clipped pixels are not fetched.

## Timing
- Two-stage pipeline, both stages clocked on pix_ce: stage 1 registers addr, window, active and sync flags from the counters; stage 2 registers RGB from img_data and forwards the flags.
- Output for counter position (h,v) appears 2 pixel ticks after the counters hold (h,v); H_sync, V_sync, de and RGB are mutually aligned.
- ROM latency is 1 CLK, satisfied because stage 2 samples CLK_DIV >= 2 cycles after addr changes.
- frame_start: high for the single CLK cycle in which stage 2 first outputs active pixel (0,0).
- Reset, including mid-frame: on the cycle init is high, div, h_cnt, v_cnt, addr, sel_q = 0; red/green/blue = 0; H_sync = V_sync = 1; de = 0; frame_start = 0. Scanning restarts from (0,0) on the first cycle after init falls.

## Test plan
- Defaults: H_sync low for exactly 384 CLK every 3200 CLK; V_sync low for 6400 CLK every 1,680,000 CLK; de high 640 ticks per line for 480 lines.
- Defaults, num=1, bank 1 = addr pattern: first window pixel (x=160, y=120) shows bank-1 word of addr 0; the last window pixel shows addr 76799; pixels at x=159 and x=480 are 12'hF00; blanking is 0.
- SCALE_LOG2=1, IMG 320x240, offsets 0: each addr is held for 2 ticks and each row is repeated on 2 lines; addr reaches 76799 at x=639, y=479.
- Switch num 0->2 mid-frame at line 300: the rest of the frame shows bank 0; the next frame shows bank 2. num=5 with NUM_IMG=3 shows bank 0.
- Assert init for 3 cycles mid-line: outputs take reset values during init; the first H_sync low is seen 2 ticks after release.
- CLK_DIV=2, X_OFF=500: window clipped at x=639; addr jumps by IMG_W per row with no fetch beyond the clip.
